// File: rtl/uart_apb2mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb2mem_pkg
// Purpose  : Shared types and helpers for the UART APB-to-mem bridge:
//            bridge FSM state encoding, strobe width and byte-merge helper.
// Contents : apb2mem_state_e, DATA_W, STRB_W, merge_bytes()
// Revision : 1.0 - initial release
// ============================================================================
package uart_apb2mem_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_RD = 2'd1,
      MEM_WR = 2'd2,
      RESP   = 2'd3
   } apb2mem_state_e;

   // Each byte lane comes from new_data when its strobe is set, otherwise
   // the previously stored byte is kept.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_data,
      input logic [DATA_W-1:0] new_data,
      input logic [STRB_W-1:0] strb
   );
      logic [DATA_W-1:0] res;
      res = old_data;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_data[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage : uart_apb2mem_pkg
`default_nettype wire

// File: rtl/uart_apb2mem.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb2mem
// Purpose  : APB4 completer bridging the peripheral bus onto the single-cycle
//            mem request interface of the UART register file. Every mem
//            request and every APB response is registered.
// Ports    : main_clk_i, main_rst_an_i (async, active-low)
//            apb_psel_i/penable_i/pwrite_i/paddr_i/pwdata_i/pstrb_i  (in)
//            apb_prdata_o/pready_o/pslverr_o                         (out)
//            mem_ena_o/addr_o/wena_o/wdata_o                         (out)
//            mem_rdata_i/err_i                                       (in)
// Options  : UART_APB2MEM_RMW_EN - partial-strobe writes become a
//            read-modify-write; otherwise they are rejected with pslverr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb2mem #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
) (
   input  logic                  main_clk_i,
   input  logic                  main_rst_an_i,
   input  logic                  apb_psel_i,
   input  logic                  apb_penable_i,
   input  logic                  apb_pwrite_i,
   input  logic [ADDR_W+1:0]     apb_paddr_i,
   input  logic [DATA_W-1:0]     apb_pwdata_i,
   input  logic [DATA_W/8-1:0]   apb_pstrb_i,
   output logic [DATA_W-1:0]     apb_prdata_o,
   output logic                  apb_pready_o,
   output logic                  apb_pslverr_o,
   output logic                  mem_ena_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic                  mem_wena_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   input  logic                  mem_err_i
);
   import uart_apb2mem_pkg::*;

   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("uart_apb2mem: DATA_W must be 32");
      end
   endgenerate

   apb2mem_state_e       state_q, state_d;
   logic                 mem_ena_q, mem_ena_d;
   logic                 mem_wena_q, mem_wena_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
   logic                 pready_q, pready_d;
   logic                 pslverr_q, pslverr_d;
   logic [DATA_W-1:0]    prdata_q, prdata_d;
`ifdef UART_APB2MEM_RMW_EN
   logic                 rmw_q, rmw_d;
   logic [STRB_W-1:0]    strb_q, strb_d;
`endif

   always_comb begin
      state_d     = state_q;
      mem_ena_d   = 1'b0;
      mem_wena_d  = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      // Response outputs are pulses: only the transition into RESP sets them.
      pready_d    = 1'b0;
      pslverr_d   = 1'b0;
      prdata_d    = '0;
`ifdef UART_APB2MEM_RMW_EN
      rmw_d       = rmw_q;
      strb_d      = strb_q;
`endif
      case (state_q)
         IDLE: begin
            // pready is always low in IDLE; the term keeps the access-phase
            // qualifier complete and obvious.
            if (apb_psel_i && apb_penable_i && !apb_pready_o) begin
               if (apb_paddr_i[1:0] != 2'b00) begin
                  state_d   = RESP;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else if (!apb_pwrite_i) begin
                  mem_addr_d = apb_paddr_i[ADDR_W+1:2];
                  mem_ena_d  = 1'b1;
                  state_d    = MEM_RD;
`ifdef UART_APB2MEM_RMW_EN
                  rmw_d      = 1'b0;
`endif
               end else if (apb_pstrb_i == '1) begin
                  mem_addr_d  = apb_paddr_i[ADDR_W+1:2];
                  mem_wdata_d = apb_pwdata_i;
                  mem_ena_d   = 1'b1;
                  mem_wena_d  = 1'b1;
                  state_d     = MEM_WR;
               end else if (apb_pstrb_i == '0) begin
                  state_d  = RESP;
                  pready_d = 1'b1;
               end else begin
`ifdef UART_APB2MEM_RMW_EN
                  // The write data is parked in the wdata register during
                  // the read; it is don't-care for the mem while wena=0.
                  mem_addr_d  = apb_paddr_i[ADDR_W+1:2];
                  mem_wdata_d = apb_pwdata_i;
                  strb_d      = apb_pstrb_i;
                  rmw_d       = 1'b1;
                  mem_ena_d   = 1'b1;
                  state_d     = MEM_RD;
`else
                  state_d   = RESP;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
`endif
               end
            end
         end
         MEM_RD: begin
`ifdef UART_APB2MEM_RMW_EN
            if (rmw_q && !mem_err_i) begin
               mem_wdata_d = merge_bytes(mem_rdata_i, mem_wdata_q, strb_q);
               mem_ena_d   = 1'b1;
               mem_wena_d  = 1'b1;
               state_d     = MEM_WR;
            end else if (rmw_q) begin
               state_d   = RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end else
`endif
            begin
               state_d   = RESP;
               pready_d  = 1'b1;
               prdata_d  = mem_rdata_i;
               pslverr_d = mem_err_i;
            end
         end
         MEM_WR: begin
            // A failed RMW read never reaches MEM_WR, so only this access's
            // error contributes.
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = mem_err_i;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         state_q     <= IDLE;
         mem_ena_q   <= 1'b0;
         mem_wena_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
`ifdef UART_APB2MEM_RMW_EN
         rmw_q       <= 1'b0;
         strb_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_ena_q   <= mem_ena_d;
         mem_wena_q  <= mem_wena_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
         prdata_q    <= prdata_d;
`ifdef UART_APB2MEM_RMW_EN
         rmw_q       <= rmw_d;
         strb_q      <= strb_d;
`endif
      end
   end

   assign mem_ena_o     = mem_ena_q;
   assign mem_wena_o    = mem_wena_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wdata_o   = mem_wdata_q;
   assign apb_pready_o  = pready_q;
   assign apb_pslverr_o = pslverr_q;
   assign apb_prdata_o  = prdata_q;

endmodule : uart_apb2mem
`default_nettype wire

// File: tb/tb_uart_apb2mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb2mem
// Purpose  : Self-checking bench for uart_apb2mem. Directed APB transfers
//            push expected mem requests and APB responses into queues; a
//            monitor pops and compares whenever the DUT presents them.
//            Follows UART_APB2MEM_RMW_EN for partial-strobe expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb2mem;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;

   logic                 clk;
   logic                 rst_an;
   logic                 psel, penable, pwrite;
   logic [ADDR_W+1:0]    paddr;
   logic [DATA_W-1:0]    pwdata;
   logic [DATA_W/8-1:0]  pstrb;
   logic [DATA_W-1:0]    prdata;
   logic                 pready, pslverr;
   logic                 mem_ena, mem_wena;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata, mem_rdata;
   logic                 mem_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic              wena;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_txn_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } resp_t;

   mem_txn_t mem_q[$];
   resp_t    resp_q[$];

   logic [DATA_W-1:0] mem [0:15];

   uart_apb2mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .main_clk_i    (clk),
      .main_rst_an_i (rst_an),
      .apb_psel_i    (psel),
      .apb_penable_i (penable),
      .apb_pwrite_i  (pwrite),
      .apb_paddr_i   (paddr),
      .apb_pwdata_i  (pwdata),
      .apb_pstrb_i   (pstrb),
      .apb_prdata_o  (prdata),
      .apb_pready_o  (pready),
      .apb_pslverr_o (pslverr),
      .mem_ena_o     (mem_ena),
      .mem_addr_o    (mem_addr),
      .mem_wena_o    (mem_wena),
      .mem_wdata_o   (mem_wdata),
      .mem_rdata_i   (mem_rdata),
      .mem_err_i     (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: word 1 decodes as an error and reads back 0.
   assign mem_err   = mem_ena && (mem_addr == 13'd1);
   assign mem_rdata = (mem_ena && !mem_err) ? mem[mem_addr[3:0]] : 32'h0;

   always @(posedge clk) begin
      if (rst_an && mem_ena && mem_wena && !mem_err) mem[mem_addr[3:0]] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_an) begin
         if (mem_ena) begin
            if (mem_q.size() == 0) begin
               check("unexpected_mem_access", {19'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               mem_txn_t t;
               t = mem_q.pop_front();
               check("mem_wena", {31'd0, mem_wena}, {31'd0, t.wena});
               check("mem_addr", {19'd0, mem_addr}, {19'd0, t.addr});
               if (t.wena) check("mem_wdata", mem_wdata, t.wdata);
            end
         end
         if (pready) begin
            if (resp_q.size() == 0) begin
               check("unexpected_pready", 32'd1, 32'd0);
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               check("prdata", prdata, r.rdata);
               check("pslverr", {31'd0, pslverr}, {31'd0, r.err});
            end
         end else if (prdata != 32'h0) begin
            check("prdata_idle_zero", prdata, 32'h0);
         end
      end
   end

   task automatic apb_xfer(input string name, input logic wr, input logic [14:0] a,
                           input logic [31:0] d, input logic [3:0] s, input int exp_lat);
      int cyc;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk); #1;
      penable = 1'b1;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (pready || cyc > 20) break;
      end
      check({name, "_latency"}, cyc, exp_lat);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      int cyc;
      psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0] = 32'h0000_0011;
      mem[2] = 32'hAABB_CCDD;
      mem[3] = 32'hDEAD_BEEF;
      mem[4] = 32'h5566_7788;
      rst_an = 1'b0;
      #2;
      check("rst_pready",  {31'd0, pready},  32'd0);
      check("rst_pslverr", {31'd0, pslverr}, 32'd0);
      check("rst_prdata",  prdata,           32'd0);
      check("rst_mem_ena", {31'd0, mem_ena}, 32'd0);
      check("rst_mem_wdata", mem_wdata,      32'd0);
      repeat (3) @(posedge clk);
      #1 rst_an = 1'b1;

      // Plain read
      mem_q.push_back('{wena: 1'b0, addr: 13'h0, wdata: 32'h0});
      resp_q.push_back('{rdata: 32'h0000_0011, err: 1'b0});
      apb_xfer("read0", 1'b0, 15'h0000, 32'h0, 4'h0, 3);

      // Full write
      mem_q.push_back('{wena: 1'b1, addr: 13'h0, wdata: 32'h0000_0001});
      resp_q.push_back('{rdata: 32'h0, err: 1'b0});
      apb_xfer("wr_full", 1'b1, 15'h0000, 32'h0000_0001, 4'hF, 3);
      check("mem0_after_write", mem[0], 32'h0000_0001);

      // Read with decode error
      mem_q.push_back('{wena: 1'b0, addr: 13'h1, wdata: 32'h0});
      resp_q.push_back('{rdata: 32'h0, err: 1'b1});
      apb_xfer("read_err", 1'b0, 15'h0004, 32'h0, 4'h0, 3);

      // Misaligned: no mem access
      resp_q.push_back('{rdata: 32'h0, err: 1'b1});
      apb_xfer("misaligned", 1'b0, 15'h0002, 32'h0, 4'h0, 2);

      // Zero-strobe write: no mem access, no error
      resp_q.push_back('{rdata: 32'h0, err: 1'b0});
      apb_xfer("wr_zero_strb", 1'b1, 15'h0008, 32'hFFFF_FFFF, 4'h0, 2);

      // Partial write
`ifdef UART_APB2MEM_RMW_EN
      mem_q.push_back('{wena: 1'b0, addr: 13'h2, wdata: 32'h0});
      mem_q.push_back('{wena: 1'b1, addr: 13'h2, wdata: 32'hAA22_CC44});
      resp_q.push_back('{rdata: 32'h0, err: 1'b0});
      apb_xfer("wr_partial", 1'b1, 15'h0008, 32'h1122_3344, 4'b0101, 4);
      mem_q.push_back('{wena: 1'b0, addr: 13'h2, wdata: 32'h0});
      resp_q.push_back('{rdata: 32'hAA22_CC44, err: 1'b0});
      apb_xfer("read_back2", 1'b0, 15'h0008, 32'h0, 4'h0, 3);
`else
      resp_q.push_back('{rdata: 32'h0, err: 1'b1});
      apb_xfer("wr_partial", 1'b1, 15'h0008, 32'h1122_3344, 4'b0101, 2);
      mem_q.push_back('{wena: 1'b0, addr: 13'h2, wdata: 32'h0});
      resp_q.push_back('{rdata: 32'hAABB_CCDD, err: 1'b0});
      apb_xfer("read_back2", 1'b0, 15'h0008, 32'h0, 4'h0, 3);
`endif

      // Full write to the erroring word
      mem_q.push_back('{wena: 1'b1, addr: 13'h1, wdata: 32'h1234_5678});
      resp_q.push_back('{rdata: 32'h0, err: 1'b1});
      apb_xfer("wr_err", 1'b1, 15'h0004, 32'h1234_5678, 4'hF, 3);

      // Another read
      mem_q.push_back('{wena: 1'b0, addr: 13'h3, wdata: 32'h0});
      resp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      apb_xfer("read3", 1'b0, 15'h000C, 32'h0, 4'h0, 3);

      // Reset during the MEM_RD cycle
      mem_q.push_back('{wena: 1'b0, addr: 13'h4, wdata: 32'h0});
      @(posedge clk); #1;
`ifdef UART_APB2MEM_RMW_EN
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 15'h0010;
      pwdata = 32'h0102_0304; pstrb = 4'b0011;
`else
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 15'h0010;
      pwdata = 32'h0; pstrb = 4'h0;
`endif
      @(posedge clk); #1;
      penable = 1'b1;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mem_ena || cyc > 20) break;
      end
      check("rst_test_mem_rd_seen", {31'd0, mem_ena}, 32'd1);
      #1 rst_an = 1'b0;
      #1;
      check("midrst_mem_ena",  {31'd0, mem_ena},  32'd0);
      check("midrst_mem_wena", {31'd0, mem_wena}, 32'd0);
      check("midrst_mem_addr", {19'd0, mem_addr}, 32'd0);
      check("midrst_pready",   {31'd0, pready},   32'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_an = 1'b1;
      repeat (6) @(posedge clk);
      check("mem4_untouched", mem[4], 32'h5566_7788);

      mem_q.push_back('{wena: 1'b0, addr: 13'h4, wdata: 32'h0});
      resp_q.push_back('{rdata: 32'h5566_7788, err: 1'b0});
      apb_xfer("read_after_rst", 1'b0, 15'h0010, 32'h0, 4'h0, 3);

      repeat (4) @(posedge clk);
      check("mem_q_drained",  mem_q.size(),  32'd0);
      check("resp_q_drained", resp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_uart_apb2mem
`default_nettype wire
